// File: rtl/rssb_memory_responder_if.sv
// CPU strobe/address and loader stream signals shared between the responder and its host.
interface rssb_memory_responder_if;
    logic [7:0] address;
    logic       re;
    logic       we;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_last;
    logic       load_ready;
    logic       cpu_run;
    logic [7:0] out_data;
    logic       out_strobe;
    logic       bus_error;

    modport master (
        output address, re, we, load_valid, load_data, load_last,
        input  load_ready, cpu_run, out_data, out_strobe, bus_error
    );

    modport slave (
        input  address, re, we, load_valid, load_data, load_last,
        output load_ready, cpu_run, out_data, out_strobe, bus_error
    );
endinterface

// File: rtl/rssb_memory_responder.sv
// 256x8 memory for the RSSB core: byte-stream loader, then CPU read/write
// service on the shared tri-state bus with an output port at 0xFF.
// The data bus is a resolved tri-state net, so it stays a plain port.
module rssb_memory_responder (
    input  logic                   clock,
    input  logic                   reset,
    inout  wire  [7:0]             data,
    rssb_memory_responder_if.slave bus
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 256;
    localparam logic [ADDR_W-1:0] OUT_ADDR = ADDR_W'(8'hFF);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(8'hFF);

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   load_ptr;
    logic [ADDR_W-1:0]   load_ptr_next;
    logic [DATA_W-1:0]   out_data_q;
    logic [DATA_W-1:0]   out_data_next;
    logic                out_strobe_q;
    logic                out_strobe_next;
    logic                bus_error_q;
    logic                bus_error_next;
    logic                load_accept;
    logic                cpu_write;
    logic                cpu_read;

    logic [DATA_W-1:0]   mem [DEPTH];

    // State, load pointer and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= LOAD;
            load_ptr     <= '0;
            out_data_q   <= '0;
            out_strobe_q <= 1'b0;
            bus_error_q  <= 1'b0;
        end else begin
            state        <= state_next;
            load_ptr     <= load_ptr_next;
            out_data_q   <= out_data_next;
            out_strobe_q <= out_strobe_next;
            bus_error_q  <= bus_error_next;
        end
    end

    // Next-state, loader acceptance and CPU access decode.
    always_comb begin
        state_next      = state;
        load_ptr_next   = load_ptr;
        out_data_next   = out_data_q;
        out_strobe_next = 1'b0;
        bus_error_next  = bus_error_q;
        load_accept     = 1'b0;
        cpu_write       = 1'b0;
        cpu_read        = 1'b0;
        case (state)
            LOAD: begin
                if (bus.load_valid) begin
                    load_accept   = 1'b1;
                    load_ptr_next = load_ptr + ADDR_W'(1);
                    if (bus.load_last || (load_ptr == LAST_PTR)) begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                cpu_read  = bus.re & ~bus.we;
                cpu_write = bus.we & ~bus.re;
                if (bus.re && bus.we) begin
                    bus_error_next = 1'b1;
                end
                if (cpu_write && (bus.address == OUT_ADDR)) begin
                    out_data_next   = data;
                    out_strobe_next = 1'b1;
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    // Memory array: loader writes in LOAD, CPU writes in RUN; never reset.
    always_ff @(posedge clock) begin
        if (load_accept && !reset) begin
            mem[load_ptr] <= bus.load_data;
        end else if (cpu_write) begin
            mem[bus.address] <= data;
        end
    end

    // Read data is combinational so the CPU can latch it in the same cycle.
    assign data = cpu_read ? mem[bus.address] : {DATA_W{1'bz}};

    assign bus.load_ready = (state == LOAD);
    assign bus.cpu_run    = (state == RUN);
    assign bus.out_data   = out_data_q;
    assign bus.out_strobe = out_strobe_q;
    assign bus.bus_error  = bus_error_q;
endmodule

// File: tb/tb_rssb_memory_responder.sv
// Scoreboard bench for rssb_memory_responder: stimulus pushes expected read
// data and port writes; a negedge monitor pops and compares.
module tb_rssb_memory_responder;
    logic       clock = 1'b0;
    logic       reset;
    tri1  [7:0] data;
    logic       cpu_drive;
    logic [7:0] cpu_value;

    assign data = cpu_drive ? cpu_value : 8'bz;

    rssb_memory_responder_if bus ();

    rssb_memory_responder dut (
        .clock (clock),
        .reset (reset),
        .data  (data),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int         errors       = 0;
    int         checks       = 0;
    int         strobe_count = 0;
    bit         rd_active    = 1'b0;
    logic [7:0] rd_q [$];
    logic [7:0] out_q [$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every port strobe and every serviced read against the queues.
    always @(negedge clock) begin
        if (bus.out_strobe === 1'b1) begin
            strobe_count++;
            if (out_q.size() == 0) check("out_strobe_unexpected", 8'(bus.out_strobe), 8'd0);
            else                   check("out_data", bus.out_data, out_q.pop_front());
        end
        if (rd_active && bus.cpu_run === 1'b1 && bus.re && !bus.we) begin
            if (rd_q.size() == 0) check("read_unexpected", data, 8'hxx);
            else                  check("read_data", data, rd_q.pop_front());
        end
    end

    task automatic cpu_idle();
        @(posedge clock); #1;
        bus.re = 1'b0; bus.we = 1'b0; cpu_drive = 1'b0; rd_active = 1'b0;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        @(posedge clock); #1;
        bus.address = a; bus.re = 1'b0; bus.we = 1'b1;
        cpu_drive = 1'b1; cpu_value = d; rd_active = 1'b0;
        if (a == 8'hFF && bus.cpu_run === 1'b1) out_q.push_back(d);
    endtask

    task automatic cpu_read(input logic [7:0] a, input logic [7:0] exp);
        @(posedge clock); #1;
        bus.address = a; bus.re = 1'b1; bus.we = 1'b0;
        cpu_drive = 1'b0; rd_active = 1'b1;
        rd_q.push_back(exp);
    endtask

    task automatic load_byte(input logic [7:0] d, input logic last);
        @(posedge clock); #1;
        bus.load_valid = 1'b1; bus.load_data = d; bus.load_last = last;
    endtask

    task automatic load_idle();
        @(posedge clock); #1;
        bus.load_valid = 1'b0; bus.load_last = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        bus.re = 1'b0; bus.we = 1'b0; cpu_drive = 1'b0; rd_active = 1'b0;
        bus.load_valid = 1'b0; bus.load_last = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        bus.address = 8'h00; bus.re = 1'b0; bus.we = 1'b0;
        bus.load_valid = 1'b0; bus.load_data = 8'h00; bus.load_last = 1'b0;
        cpu_drive = 1'b0; cpu_value = 8'h00;

        // Reset values.
        @(negedge clock);
        check("rst_load_ready", 8'(bus.load_ready), 8'd1);
        check("rst_cpu_run",    8'(bus.cpu_run),    8'd0);
        check("rst_out_data",   bus.out_data,       8'h00);
        check("rst_out_strobe", 8'(bus.out_strobe), 8'd0);
        check("rst_bus_error",  8'(bus.bus_error),  8'd0);
        check("rst_data_z",     data,               8'hFF);
        @(posedge clock); #1 reset = 1'b0;

        // Short load with load_last on the 4th byte.
        load_byte(8'h05, 1'b0);
        load_byte(8'h06, 1'b0);
        load_byte(8'h07, 1'b0);
        load_byte(8'h08, 1'b1);
        @(negedge clock);
        check("cpu_run_before_last",    8'(bus.cpu_run),    8'd0);
        check("load_ready_before_last", 8'(bus.load_ready), 8'd1);
        load_idle();
        @(negedge clock);
        check("cpu_run_after_last",    8'(bus.cpu_run),    8'd1);
        check("load_ready_after_last", 8'(bus.load_ready), 8'd0);
        cpu_read(8'h00, 8'h05);
        cpu_read(8'h01, 8'h06);
        cpu_read(8'h02, 8'h07);
        cpu_read(8'h03, 8'h08);

        // Write then read back; no re leaves the bus floating.
        cpu_write(8'h10, 8'h3C);
        cpu_read(8'h10, 8'h3C);
        cpu_idle();
        @(negedge clock);
        check("data_z_no_re", data, 8'hFF);

        // Back-to-back writes to the output port.
        cpu_write(8'hFF, 8'hA5);
        cpu_write(8'hFF, 8'h5A);
        cpu_idle();
        cpu_idle();
        @(negedge clock);
        check("strobe_count",     8'(strobe_count),   8'd2);
        check("out_strobe_idle",  8'(bus.out_strobe), 8'd0);
        check("out_data_hold",    bus.out_data,       8'h5A);
        cpu_read(8'hFF, 8'h5A);

        // Read/write collision.
        cpu_write(8'h20, 8'h11);
        @(posedge clock); #1;
        bus.address = 8'h20; bus.re = 1'b1; bus.we = 1'b1;
        cpu_drive = 1'b1; cpu_value = 8'h99; rd_active = 1'b0;
        @(negedge clock);
        check("bus_error_before", 8'(bus.bus_error), 8'd0);
        cpu_idle();
        @(negedge clock);
        check("bus_error_set", 8'(bus.bus_error), 8'd1);
        cpu_read(8'h20, 8'h11);
        cpu_idle();
        cpu_idle();
        cpu_idle();
        @(negedge clock);
        check("bus_error_sticky", 8'(bus.bus_error), 8'd1);

        // Full 256-byte load without load_last.
        do_reset();
        @(negedge clock);
        check("rst2_bus_error",  8'(bus.bus_error),  8'd0);
        check("rst2_cpu_run",    8'(bus.cpu_run),    8'd0);
        check("rst2_out_data",   bus.out_data,       8'h00);
        check("rst2_load_ready", 8'(bus.load_ready), 8'd1);
        for (int i = 0; i < 256; i++) load_byte(8'(i * 3 + 1), 1'b0);
        @(negedge clock);
        check("cpu_run_before_255", 8'(bus.cpu_run), 8'd0);
        load_byte(8'hEE, 1'b0);
        @(negedge clock);
        check("cpu_run_after_255",    8'(bus.cpu_run),    8'd1);
        check("load_ready_after_255", 8'(bus.load_ready), 8'd0);
        load_idle();
        cpu_read(8'h00, 8'h01);
        cpu_read(8'h80, 8'h81);
        cpu_read(8'hFF, 8'hFE);
        cpu_read(8'h05, 8'h10);

        // Reset mid-load, CPU write ignored in LOAD, then reload.
        do_reset();
        @(negedge clock);
        bus.address = 8'h00; bus.re = 1'b1;
        #1 check("load_data_z", data, 8'hFF);
        cpu_write(8'h05, 8'h77);
        cpu_idle();
        load_byte(8'hC0, 1'b0);
        load_byte(8'hC1, 1'b0);
        do_reset();
        @(negedge clock);
        check("rst3_cpu_run",  8'(bus.cpu_run), 8'd0);
        check("rst3_out_data", bus.out_data,    8'h00);
        load_byte(8'hE0, 1'b0);
        load_byte(8'hE1, 1'b1);
        @(negedge clock);
        check("cpu_run_mid_reload", 8'(bus.cpu_run), 8'd0);
        load_idle();
        @(negedge clock);
        check("cpu_run_reloaded", 8'(bus.cpu_run), 8'd1);
        cpu_read(8'h00, 8'hE0);
        cpu_read(8'h01, 8'hE1);
        cpu_read(8'h02, 8'h07);
        cpu_read(8'h05, 8'h10);
        cpu_idle();
        cpu_idle();

        @(negedge clock);
        check("rd_q_left",  8'(rd_q.size()),  8'd0);
        check("out_q_left", 8'(out_q.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
